// File: rtl/fir_coef_loader.sv
// Coefficient loader for the 27-tap FIR: streams coefficients into a shadow bank and commits them atomically.
// Define FIR_COEF_SYM_EN for a symmetric (linear-phase) load of (NTAP+1)/2 beats that are mirrored on commit.
module fir_coef_loader #(
  parameter int NTAP = 27,
  parameter int CW   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [CW-1:0]      s_data,
  input  logic               s_last,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [NTAP*CW-1:0] h_buf,
  output logic               en_n,
  output logic               clr
);

`ifdef FIR_COEF_SYM_EN
  localparam int NBEAT = (NTAP + 1) / 2;
`else
  localparam int NBEAT = NTAP;
`endif
  localparam int IW = $clog2(NBEAT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, CLEAR} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [CW-1:0] shadow [NBEAT];
  logic [CW-1:0] active [NTAP];

  // NOTE: the active bank is reset explicitly because the filter must see all-zero taps after rst,
  // so this bank maps to flops rather than to a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      s_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      clr     <= 1'b0;
      en_n    <= 1'b1;
      for (int k = 0; k < NBEAT; k++) shadow[k] <= '0;
      for (int k = 0; k < NTAP; k++)  active[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads the pre-edge state.
      done <= 1'b0;
      err  <= 1'b0;
      clr  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            idx     <= '0;
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          if (s_valid) begin
            shadow[idx] <= s_data;
            idx         <= idx + 1'b1;
            if (idx == IW'(NBEAT - 1) && s_last) begin
              state   <= COMMIT;
              s_ready <= 1'b0;
              en_n    <= 1'b1;
            end else if (idx == IW'(NBEAT - 1) || s_last) begin
              // Framing error: drop the set and leave the filter on its current coefficients.
              state   <= IDLE;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              err     <= 1'b1;
            end
          end
        end
        COMMIT: begin
          for (int k = 0; k < NBEAT; k++) begin
            active[k] <= shadow[k];
`ifdef FIR_COEF_SYM_EN
            active[NTAP-1-k] <= shadow[k];
`endif
          end
          state <= CLEAR;
          done  <= 1'b1;
          clr   <= 1'b1;
        end
        CLEAR: begin
          state <= IDLE;
          busy  <= 1'b0;
          en_n  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NTAP; g++) begin : g_hbuf
    assign h_buf[g*CW +: CW] = active[g];
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Self-checking bench for fir_coef_loader: directed and random coefficient sets against a tap-level model.
// Follows FIR_COEF_SYM_EN the same way the design does.
module tb_fir_coef_loader;
  localparam int NTAP = 27;
  localparam int CW   = 9;
`ifdef FIR_COEF_SYM_EN
  localparam int NB  = (NTAP + 1) / 2;
  localparam bit SYM = 1'b1;
`else
  localparam int NB  = NTAP;
  localparam bit SYM = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst, start, s_valid, s_last;
  logic [CW-1:0]      s_data;
  logic               s_ready, busy, done, err, en_n, clr;
  logic [NTAP*CW-1:0] h_buf;

  int                 coef [NTAP];
  logic [NTAP*CW-1:0] exp_bank;
  logic               exp_en_idle;
  int                 n_checks = 0;
  int                 n_fail   = 0;

  fir_coef_loader #(.NTAP(NTAP), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .busy(busy), .done(done), .err(err),
    .h_buf(h_buf), .en_n(en_n), .clr(clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NTAP*CW-1:0] obs, input logic [NTAP*CW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Tap k takes coefficient k, or in symmetric mode the coefficient of its mirror-nearest half index.
  function automatic logic [NTAP*CW-1:0] model_bank();
    logic [NTAP*CW-1:0] r;
    int src;
    int v;
    r = '0;
    for (int k = 0; k < NTAP; k++) begin
      src = (SYM && (NTAP - 1 - k) < k) ? (NTAP - 1 - k) : k;
      v = coef[src];
      r[k*CW +: CW] = v[CW-1:0];
    end
    return r;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < NTAP; k++) coef[k] = int'($urandom_range(0, 511)) - 256;
  endtask

  // Sends beats 0..n-1, s_last on beat last_pos; returns in the cycle after the final beat.
  task automatic load_beats(input string name, input int n, input int last_pos, input bit gaps, input bit restart);
    int v;
    start = 1'b1;
    step();
    start = 1'b0;
    check({name, ".ready"}, s_ready, 1'b1);
    check({name, ".busy"},  busy,    1'b1);
    check({name, ".en_n_load"}, en_n, exp_en_idle);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        s_valid = 1'b0;
        s_data  = CW'($urandom);
        s_last  = 1'($urandom);
        step();
        check({name, ".gap_ready"}, s_ready, 1'b1);
      end
      v       = coef[i];
      s_valid = 1'b1;
      s_data  = v[CW-1:0];
      s_last  = (i == last_pos);
      start   = restart && (i == 5);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    start   = 1'b0;
  endtask

  task automatic expect_commit(input string name);
    check({name, ".commit_en_n"},  en_n,    1'b1);
    check({name, ".commit_busy"},  busy,    1'b1);
    check({name, ".commit_ready"}, s_ready, 1'b0);
    check({name, ".commit_done"},  done,    1'b0);
    check({name, ".commit_old"},   h_buf,   exp_bank);
    exp_bank = model_bank();
    step();
    check({name, ".done"},      done,  1'b1);
    check({name, ".clr"},       clr,   1'b1);
    check({name, ".clear_en"},  en_n,  1'b1);
    check({name, ".h_buf"},     h_buf, exp_bank);
    exp_en_idle = 1'b0;
    step();
    check({name, ".idle_en_n"}, en_n,  1'b0);
    check({name, ".idle_busy"}, busy,  1'b0);
    check({name, ".idle_done"}, done,  1'b0);
    check({name, ".idle_clr"},  clr,   1'b0);
  endtask

  task automatic expect_abort(input string name);
    check({name, ".err"},   err,     1'b1);
    check({name, ".busy"},  busy,    1'b0);
    check({name, ".ready"}, s_ready, 1'b0);
    check({name, ".done"},  done,    1'b0);
    check({name, ".en_n"},  en_n,    exp_en_idle);
    check({name, ".bank"},  h_buf,   exp_bank);
    step();
    check({name, ".err_pulse"}, err,   1'b0);
    check({name, ".no_done"},   done,  1'b0);
    check({name, ".bank2"},     h_buf, exp_bank);
    check({name, ".en_n2"},     en_n,  exp_en_idle);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    exp_bank = '0;
    exp_en_idle = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Idle after reset: zero bank, filter held disabled, nothing pulses.
    for (int c = 0; c < 5; c++) begin
      step();
      check("rst.done", done, 1'b0);
      check("rst.err",  err,  1'b0);
    end
    check("rst.h_buf", h_buf,   '0);
    check("rst.en_n",  en_n,    1'b1);
    check("rst.ready", s_ready, 1'b0);
    check("rst.busy",  busy,    1'b0);
    check("rst.clr",   clr,     1'b0);

    // Ramp k-13 back-to-back.
    for (int k = 0; k < NTAP; k++) coef[k] = k - 13;
    load_beats("ramp", NB, NB - 1, 1'b0, 1'b0);
    expect_commit("ramp");

    // Values 1..N (mirrored in symmetric mode).
    for (int k = 0; k < NTAP; k++) coef[k] = k + 1;
    load_beats("inc", NB, NB - 1, 1'b0, 1'b0);
    expect_commit("inc");

    // Random set with valid gaps and a stray start mid-load.
    fill_random();
    load_beats("gaps", NB, NB - 1, 1'b1, 1'b1);
    expect_commit("gaps");

    // Early s_last on beat 5.
    fill_random();
    load_beats("early", 6, 5, 1'b0, 1'b0);
    expect_abort("early");

    // Missing s_last on the final beat.
    fill_random();
    load_beats("nolast", NB, -1, 1'b0, 1'b0);
    expect_abort("nolast");

    // Extremes of the signed range pass through unchanged.
    for (int k = 0; k < NTAP; k++) coef[k] = (k % 2 == 0) ? -256 : 255;
    load_beats("ext", NB, NB - 1, 1'b0, 1'b0);
    expect_commit("ext");

    // Reset mid-load after 10 beats, then a fresh random load.
    fill_random();
    load_beats("rstmid", 10, -1, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_bank = '0;
    exp_en_idle = 1'b1;
    check("rstmid.h_buf", h_buf,   exp_bank);
    check("rstmid.en_n",  en_n,    1'b1);
    check("rstmid.busy",  busy,    1'b0);
    check("rstmid.ready", s_ready, 1'b0);
    step();
    fill_random();
    load_beats("fresh", NB, NB - 1, 1'b1, 1'b0);
    expect_commit("fresh");

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
